// File: rtl/convolver_complex.sv
// Streaming KxK fixed-point convolver over an NxN row-major image.
// A chain of K-tap window rows and (N-K)-deep line buffers holds the last
// K image rows; every accepted pixel completing a valid window yields one
// result a cycle later.
// Optional macro CONVOLVER_COMPLEX_SAT_EN: saturate the accumulator to DW
// bits instead of truncating it.
// The v_data_out_*/v_data_hold_* observation ports assume KERNEL_SIZE = 5.
module convolver_complex #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BIT    = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int IMAGE_SIZE  = 28
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              write,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     weights_matrix,
  input  logic [DATA_WIDTH-1:0]                             pixel_in,
  input  logic [DATA_WIDTH-1:0]                             bias,
  output logic [DATA_WIDTH-1:0]                             conv_final_result,
  output logic                                              enable_signal,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     v_weights_out,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0]                 v_data_out_0,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0]                 v_data_out_1,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0]                 v_data_out_2,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0]                 v_data_out_3,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0]                 v_data_out_4,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     v_mult_result,
  output logic [(IMAGE_SIZE-KERNEL_SIZE)*DATA_WIDTH-1:0]    v_data_hold_0,
  output logic [(IMAGE_SIZE-KERNEL_SIZE)*DATA_WIDTH-1:0]    v_data_hold_1,
  output logic [(IMAGE_SIZE-KERNEL_SIZE)*DATA_WIDTH-1:0]    v_data_hold_2,
  output logic [(IMAGE_SIZE-KERNEL_SIZE)*DATA_WIDTH-1:0]    v_data_hold_3
);

  localparam int DW    = DATA_WIDTH;
  localparam int K     = KERNEL_SIZE;
  localparam int N     = IMAGE_SIZE;
  localparam int HW    = N - K;
  localparam int KK    = K * K;
  localparam int CW    = $clog2(N);
  // Room for KK products plus bias without overflow.
  localparam int ACC_W = DW + $clog2(KK + 1);

  // Element 0 is the newest entry; row 0 holds the oldest image row.
  logic [DW-1:0] row_q  [K][K];
  logic [DW-1:0] hold_q [K-1][HW];

  logic [CW-1:0]           row_cnt_q, col_cnt_q;
  logic                    pend_q;
  logic                    win_valid;
  logic signed [2*DW-1:0]  prod;
  logic [DW-1:0]           mult [KK];
  logic signed [ACC_W-1:0] acc;
  logic [DW-1:0]           acc_red;

  // Counters hold the position of the next pixel to be accepted.
  assign win_valid = (row_cnt_q >= CW'(K - 1)) && (col_cnt_q >= CW'(K - 1));

  // Shift the window/line-buffer chain on every accepted pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < K; r++) begin
        for (int e = 0; e < K; e++) row_q[r][e] <= '0;
      end
      for (int h = 0; h < K - 1; h++) begin
        for (int e = 0; e < HW; e++) hold_q[h][e] <= '0;
      end
    end else if (write) begin
      row_q[K-1][0] <= pixel_in;
      for (int r = 0; r < K - 1; r++) row_q[r][0] <= hold_q[r][HW-1];
      for (int r = 0; r < K; r++) begin
        for (int e = 1; e < K; e++) row_q[r][e] <= row_q[r][e-1];
      end
      for (int h = 0; h < K - 1; h++) begin
        hold_q[h][0] <= row_q[h+1][K-1];
        for (int e = 1; e < HW; e++) hold_q[h][e] <= hold_q[h][e-1];
      end
    end
  end

  // Track image position and flag a completed window for the next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      pend_q <= write && win_valid;
      if (write) begin
        if (col_cnt_q == CW'(N - 1)) begin
          col_cnt_q <= '0;
          row_cnt_q <= (row_cnt_q == CW'(N - 1)) ? '0 : row_cnt_q + CW'(1);
        end else begin
          col_cnt_q <= col_cnt_q + CW'(1);
        end
      end
    end
  end

  // Per-tap scaled products and their sum; weight column c pairs with
  // element K-1-c so column 0 meets the oldest (leftmost) pixel.
  always_comb begin
    prod = '0;
    acc  = ACC_W'($signed(bias));
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        prod = $signed(weights_matrix[(r*K+c)*DW +: DW]) * $signed(row_q[r][K-1-c]);
        mult[r*K+c] = DW'(prod >>> FRAC_BIT);
        acc = acc + ACC_W'($signed(mult[r*K+c]));
      end
    end
  end

`ifdef CONVOLVER_COMPLEX_SAT_EN
  localparam logic signed [ACC_W-1:0] AccMax = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Clamp the accumulator into the DW-bit signed range.
  always_comb begin
    if (acc > AccMax) begin
      acc_red = {1'b0, {(DW-1){1'b1}}};
    end else if (acc < AccMin) begin
      acc_red = {1'b1, {(DW-1){1'b0}}};
    end else begin
      acc_red = DW'(acc);
    end
  end
`else
  // Wrap-around: keep the low DW bits.
  always_comb begin
    acc_red = DW'(acc);
  end
`endif

  // Register the result one edge after the window-completing pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conv_final_result <= '0;
      enable_signal     <= 1'b0;
    end else begin
      enable_signal <= pend_q;
      if (pend_q) conv_final_result <= acc_red;
    end
  end

  assign v_weights_out = weights_matrix;

  // Pack internal state onto the observation ports.
  always_comb begin
    for (int e = 0; e < K; e++) begin
      v_data_out_0[e*DW +: DW] = row_q[0][e];
      v_data_out_1[e*DW +: DW] = row_q[1][e];
      v_data_out_2[e*DW +: DW] = row_q[2][e];
      v_data_out_3[e*DW +: DW] = row_q[3][e];
      v_data_out_4[e*DW +: DW] = row_q[4][e];
    end
    for (int e = 0; e < HW; e++) begin
      v_data_hold_0[e*DW +: DW] = hold_q[0][e];
      v_data_hold_1[e*DW +: DW] = hold_q[1][e];
      v_data_hold_2[e*DW +: DW] = hold_q[2][e];
      v_data_hold_3[e*DW +: DW] = hold_q[3][e];
    end
    for (int i = 0; i < KK; i++) v_mult_result[i*DW +: DW] = mult[i];
  end

endmodule

// File: tb/tb_convolver_complex.sv
// Bench for convolver_complex: an image-array reference model plus directed
// scenarios with literal expectations.
module tb_convolver_complex;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int K  = 5;
  localparam int N  = 28;
  localparam int KK = K * K;
  localparam int HW = N - K;

  logic                clk = 1'b0;
  logic                reset;
  logic                write;
  logic [KK*DW-1:0]    weights_matrix;
  logic [DW-1:0]       pixel_in;
  logic [DW-1:0]       bias;
  logic [DW-1:0]       conv_final_result;
  logic                enable_signal;
  logic [KK*DW-1:0]    v_weights_out;
  logic [K*DW-1:0]     v_data_out_0, v_data_out_1, v_data_out_2, v_data_out_3, v_data_out_4;
  logic [KK*DW-1:0]    v_mult_result;
  logic [HW*DW-1:0]    v_data_hold_0, v_data_hold_1, v_data_hold_2, v_data_hold_3;

  convolver_complex #(
    .DATA_WIDTH (DW),
    .FRAC_BIT   (FB),
    .KERNEL_SIZE(K),
    .IMAGE_SIZE (N)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .write            (write),
    .weights_matrix   (weights_matrix),
    .pixel_in         (pixel_in),
    .bias             (bias),
    .conv_final_result(conv_final_result),
    .enable_signal    (enable_signal),
    .v_weights_out    (v_weights_out),
    .v_data_out_0     (v_data_out_0),
    .v_data_out_1     (v_data_out_1),
    .v_data_out_2     (v_data_out_2),
    .v_data_out_3     (v_data_out_3),
    .v_data_out_4     (v_data_out_4),
    .v_mult_result    (v_mult_result),
    .v_data_hold_0    (v_data_hold_0),
    .v_data_hold_1    (v_data_hold_1),
    .v_data_hold_2    (v_data_hold_2),
    .v_data_hold_3    (v_data_hold_3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int en_cnt = 0;
  int first_en_at = -1;
  logic [DW-1:0] res_q [$];

  // Reference model state: the current frame as a plain 2-D image.
  logic signed [DW-1:0] img [N][N];
  int            m_row = 0;
  int            m_col = 0;
  logic          m_pend = 1'b0;
  logic [DW-1:0] m_pend_val = '0;
  logic          m_en = 1'b0;
  logic [DW-1:0] m_res = '0;

  function automatic logic [DW-1:0] model_result(input int row, input int col);
    longint acc;
    longint p;
    logic signed [DW-1:0] t;
    acc = longint'($signed(bias));
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        p = longint'($signed(weights_matrix[(r*K+c)*DW +: DW])) *
            longint'(img[row-K+1+r][col-K+1+c]);
        p = p >>> FB;
        t = p[DW-1:0];
        acc += longint'(t);
      end
    end
`ifdef CONVOLVER_COMPLEX_SAT_EN
    if (acc > 32767) return 16'h7FFF;
    if (acc < -32768) return 16'h8000;
`endif
    return acc[DW-1:0];
  endfunction

  // Model: what the outputs must be after each edge.
  always begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_row = 0; m_col = 0; m_pend = 1'b0; m_en = 1'b0; m_res = '0;
    end else begin
      m_en = m_pend;
      if (m_pend) m_res = m_pend_val;
      m_pend = 1'b0;
      if (write) begin
        img[m_row][m_col] = pixel_in;
        if (m_row >= K - 1 && m_col >= K - 1) begin
          m_pend = 1'b1;
          m_pend_val = model_result(m_row, m_col);
        end
        if (m_col == N - 1) begin
          m_col = 0;
          m_row = (m_row == N - 1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end
    end
  end

  // Compare DUT outputs with the model every cycle out of reset.
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      checks++;
      if ({enable_signal, conv_final_result} !== {m_en, m_res}) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t: got en=%b res=%h expected en=%b res=%h",
                 $time, enable_signal, conv_final_result, m_en, m_res);
      end
      if (enable_signal === 1'b1) begin
        en_cnt++;
        if (first_en_at < 0) first_en_at = acc_cnt;
        res_q.push_back(conv_final_result);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; idle cycles also verify the window did not move.
  task automatic drive(input logic wr, input logic [DW-1:0] pix);
    logic [127:0] snap4, snap0;
    @(negedge clk);
    write = wr;
    pixel_in = pix;
    if (wr) begin
      acc_cnt++;
    end else begin
      snap4 = 128'(v_data_out_4);
      snap0 = 128'(v_data_out_0);
      @(posedge clk);
      #1;
      chk("stall_row4", 128'(v_data_out_4), snap4);
      chk("stall_row0", 128'(v_data_out_0), snap0);
    end
  endtask

  task automatic begin_test();
    acc_cnt = 0;
    en_cnt = 0;
    first_en_at = -1;
    res_q.delete();
  endtask

  task automatic apply_reset(input logic [DW-1:0] w, input logic [DW-1:0] b);
    @(negedge clk);
    reset = 1'b0;
    write = 1'b0;
    for (int i = 0; i < KK; i++) weights_matrix[i*DW +: DW] = w;
    bias = b;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    begin_test();
  endtask

  initial begin
    reset = 1'b0;
    write = 1'b0;
    pixel_in = '0;
    bias = '0;
    weights_matrix = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_result", 128'(conv_final_result), 128'(16'h0000));
    chk("rst_enable", 128'(enable_signal), 128'(1'b0));
    chk("rst_row4", 128'(v_data_out_4), 128'(0));
    chk("rst_hold3", v_data_hold_3[127:0], 128'(0));

    // Constant frame: 1.5 * 1.25 per tap, bias 3.0.
    apply_reset(16'h0180, 16'h0300);
    for (int i = 0; i < N * N; i++) drive(1'b1, 16'h0140);
    drive(1'b0, '0);
    drive(1'b0, '0);
    chk("first_enable_pixel", 128'(first_en_at), 128'(118));
    chk("frame_results", 128'(en_cnt), 128'(576));
    chk("const_result_first", 128'(res_q[0]), 128'(16'h31E0));
    chk("const_result_last", 128'(res_q[575]), 128'(16'h31E0));
    for (int i = 0; i < KK; i++) chk("mult_slice", 128'(v_mult_result[i*DW +: DW]), 128'(16'h01E0));
    chk("weights_copy", 128'(v_weights_out[127:0]), {8{16'h0180}});

    // Second frame, write toggling every cycle; counters wrapped to (0,0).
    begin_test();
    for (int i = 0; i < N * N; i++) begin
      drive(1'b1, 16'h0140);
      drive(1'b0, '0);
    end
    drive(1'b0, '0);
    chk("toggle_first_enable", 128'(first_en_at), 128'(117));
    chk("toggle_results", 128'(en_cnt), 128'(576));
    chk("toggle_result_first", 128'(res_q[0]), 128'(16'h31E0));
    chk("toggle_result_last", 128'(res_q[575]), 128'(16'h31E0));

    // Overflow: 16.0 * 4.0 over 25 taps.
    apply_reset(16'h1000, 16'h0000);
    for (int i = 0; i < 120; i++) drive(1'b1, 16'h0400);
    drive(1'b0, '0);
    drive(1'b0, '0);
`ifdef CONVOLVER_COMPLEX_SAT_EN
    chk("overflow_result", 128'(res_q[0]), 128'(16'h7FFF));
`else
    chk("overflow_result", 128'(res_q[0]), 128'(16'h4000));
`endif

    // Ramp with only the top-left weight at 1.0, idle gaps every 5 pixels.
    apply_reset(16'h0000, 16'h0000);
    weights_matrix[DW-1:0] = 16'h0100;
    for (int i = 0; i < N * N; i++) begin
      drive(1'b1, 16'(i));
      if (i % 5 == 4) drive(1'b0, '0);
    end
    drive(1'b0, '0);
    drive(1'b0, '0);
    chk("ramp_results", 128'(en_cnt), 128'(576));
    chk("ramp_res0", 128'(res_q[0]), 128'(16'd0));
    chk("ramp_res1", 128'(res_q[1]), 128'(16'd1));
    chk("ramp_res23", 128'(res_q[23]), 128'(16'd23));
    chk("ramp_res24", 128'(res_q[24]), 128'(16'd28));
    chk("ramp_res575", 128'(res_q[575]), 128'(16'd667));

    // Reset aborting a frame after 300 pixels.
    apply_reset(16'h0180, 16'h0300);
    for (int i = 0; i < 300; i++) drive(1'b1, 16'(i * 3));
    @(negedge clk);
    reset = 1'b0;
    write = 1'b0;
    #1;
    chk("abort_result", 128'(conv_final_result), 128'(16'h0000));
    chk("abort_enable", 128'(enable_signal), 128'(1'b0));
    chk("abort_row4", 128'(v_data_out_4), 128'(0));
    chk("abort_hold3", v_data_hold_3[127:0], 128'(0));
    @(negedge clk);
    reset = 1'b1;
    begin_test();
    for (int i = 0; i < 130; i++) drive(1'b1, 16'(i + 7));
    drive(1'b0, '0);
    drive(1'b0, '0);
    chk("restart_first_enable", 128'(first_en_at), 128'(118));
    chk("restart_results", 128'(en_cnt), 128'(14));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
